matmul_loop_ctrl: RTL and testbench

- Sequencing controller for the single-core matrix multiplier.
- Computes C[M×P] = A[M×N] · B[N×P] by walking the row index i, column index j and inner index k.
- Drives memory read/write enables, linear addresses for A/B/C, and MAC accumulator clear/enable strobes.
- Owns the loop counters that the index registers previously held, with start/done handshake to the top-level.

---
 rtl/matmul_loop_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_matmul_loop_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_loop_ctrl.sv
// matmul_loop_ctrl -- sequencing controller for the single-core matrix multiplier.
//
// Computes C[M x P] = A[M x N] * B[N x P] by walking row index i, column index j
// and inner index k. For each C element the sequence is: clear the accumulator,
// then for every k issue a read, wait out the memory latency and accumulate,
// and finally write the accumulator back to C.
//
// Parameters:
//   DATA_WIDTH : width of the dimension inputs and of the i/j/k indices
//   MEM_LAT    : cycles from rd_en to operand valid at the MAC (>= 1)
//
// Ports:
//   clk, rst_n            : rising-edge clock, asynchronous active-low reset
//   start                 : begin a multiply (sampled only while idle)
//   dim_m, dim_n, dim_p   : matrix dimensions, latched on the accepted start
//   busy                  : high in every state except idle
//   done                  : one-cycle completion pulse
//   err                   : sticky, last start had a zero dimension
//   i_idx, j_idx, k_idx   : current loop indices
//   rd_en, addr_a, addr_b : operand read strobe, A address i*N+k, B address k*P+j
//   wr_en, addr_c         : result write strobe, C address i*P+j
//   mac_clr, mac_en       : accumulator clear / accumulate strobes
//
// Optional feature (macro MATMUL_CTRL_ABORT_EN):
//   abort   : input, cancels a run from any busy state except DONE
//   aborted : output, one-cycle pulse in the cycle after an accepted abort

module matmul_loop_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_LAT    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     dim_m,
    input  logic [DATA_WIDTH-1:0]     dim_n,
    input  logic [DATA_WIDTH-1:0]     dim_p,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [DATA_WIDTH-1:0]     i_idx,
    output logic [DATA_WIDTH-1:0]     j_idx,
    output logic [DATA_WIDTH-1:0]     k_idx,
    output logic                      rd_en,
    output logic [2*DATA_WIDTH-1:0]   addr_a,
    output logic [2*DATA_WIDTH-1:0]   addr_b,
    output logic                      wr_en,
    output logic [2*DATA_WIDTH-1:0]   addr_c,
    output logic                      mac_clr,
    output logic                      mac_en
`ifdef MATMUL_CTRL_ABORT_EN
    ,
    input  logic                      abort,
    output logic                      aborted
`endif
);

    localparam int AW = 2 * DATA_WIDTH;

    // WAIT occupies MEM_LAT-1 cycles; the counter is sized for at least one
    // bit so the design stays legal when MEM_LAT==1 and WAIT is unreachable.
    localparam int unsigned WAIT_CYC = (MEM_LAT > 1) ? MEM_LAT - 1 : 1;
    localparam int unsigned LAT_W    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [LAT_W-1:0] LAT_END = LAT_W'(WAIT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RD,
        S_WAIT,
        S_MAC,
        S_WR,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  m_q, m_d;
    logic [DATA_WIDTH-1:0]  n_q, n_d;
    logic [DATA_WIDTH-1:0]  p_q, p_d;
    logic [DATA_WIDTH-1:0]  i_q, i_d;
    logic [DATA_WIDTH-1:0]  j_q, j_d;
    logic [DATA_WIDTH-1:0]  k_q, k_d;
    logic                   err_q, err_d;
    logic [LAT_W-1:0]       lat_q, lat_d;
`ifdef MATMUL_CTRL_ABORT_EN
    logic                   aborted_q, aborted_d;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Loop counters, latched dimensions, error flag and latency counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q   <= '0;
            n_q   <= '0;
            p_q   <= '0;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            err_q <= 1'b0;
            lat_q <= '0;
        end else begin
            m_q   <= m_d;
            n_q   <= n_d;
            p_q   <= p_d;
            i_q   <= i_d;
            j_q   <= j_d;
            k_q   <= k_d;
            err_q <= err_d;
            lat_q <= lat_d;
        end
    end

`ifdef MATMUL_CTRL_ABORT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= aborted_d;
        end
    end

    assign aborted = aborted_q;
`endif

    // Next-state, counter updates and strobes
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        n_d     = n_q;
        p_d     = p_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        err_d   = err_q;
        lat_d   = lat_q;
        busy    = (state_q != S_IDLE);
        done    = 1'b0;
        mac_clr = 1'b0;
        rd_en   = 1'b0;
        mac_en  = 1'b0;
        wr_en   = 1'b0;
`ifdef MATMUL_CTRL_ABORT_EN
        aborted_d = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (dim_m == '0 || dim_n == '0 || dim_p == '0) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        m_d     = dim_m;
                        n_d     = dim_n;
                        p_d     = dim_p;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                        err_d   = 1'b0;
                        state_d = S_CLR;
                    end
                end
            end
            S_CLR: begin
                mac_clr = 1'b1;
                state_d = S_RD;
            end
            S_RD: begin
                rd_en   = 1'b1;
                lat_d   = '0;
                state_d = (MEM_LAT > 1) ? S_WAIT : S_MAC;
            end
            S_WAIT: begin
                if (lat_q == LAT_END) begin
                    state_d = S_MAC;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_MAC: begin
                mac_en = 1'b1;
                // Compare against dim-1 before incrementing so a dimension of
                // 2^DATA_WIDTH-1 never wraps the index.
                if (k_q == n_q - 1'b1) begin
                    state_d = S_WR;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = S_RD;
                end
            end
            S_WR: begin
                wr_en = 1'b1;
                k_d   = '0;
                if (j_q != p_q - 1'b1) begin
                    j_d     = j_q + 1'b1;
                    state_d = S_CLR;
                end else if (i_q != m_q - 1'b1) begin
                    j_d     = '0;
                    i_d     = i_q + 1'b1;
                    state_d = S_CLR;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef MATMUL_CTRL_ABORT_EN
        // Abort overrides whatever the case above chose; DONE is allowed to
        // finish so a completed run is never reported as aborted.
        if (abort && state_q != S_IDLE && state_q != S_DONE) begin
            state_d   = S_IDLE;
            i_d       = '0;
            j_d       = '0;
            k_d       = '0;
            aborted_d = 1'b1;
        end
`endif
    end

    assign err   = err_q;
    assign i_idx = i_q;
    assign j_idx = j_q;
    assign k_idx = k_q;

    // Full-width unsigned address arithmetic from indices and latched dims
    assign addr_a = AW'(i_q) * AW'(n_q) + AW'(k_q);
    assign addr_b = AW'(k_q) * AW'(p_q) + AW'(j_q);
    assign addr_c = AW'(i_q) * AW'(p_q) + AW'(j_q);

endmodule

// File: tb/tb_matmul_loop_ctrl.sv
// tb_matmul_loop_ctrl -- self-checking bench for matmul_loop_ctrl.
// Two instances share the clock: one with MEM_LAT=2, one with MEM_LAT=1.
// Expected per-cycle behaviour is produced by a loop-nest model that lists
// the operations each C element needs, in order.

module tb_matmul_loop_ctrl;

    localparam int W  = 8;
    localparam int AW = 2 * W;

    typedef struct packed {
        logic [3:0]   strb;   // {mac_clr, rd_en, mac_en, wr_en}
        logic         dn;
        logic [W-1:0] i;
        logic [W-1:0] j;
        logic [W-1:0] k;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [1:0] start_i;
    logic [W-1:0] dm, dn, dp;

    logic [1:0] busy_o, done_o, err_o, rd_o, wr_o, clr_o, mac_o;
    logic [1:0][W-1:0]  i_o, j_o, k_o;
    logic [1:0][AW-1:0] aa_o, ab_o, ac_o;
`ifdef MATMUL_CTRL_ABORT_EN
    logic [1:0] abort_i, aborted_o;
`endif

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    matmul_loop_ctrl #(.DATA_WIDTH(W), .MEM_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_i[0]),
        .dim_m(dm), .dim_n(dn), .dim_p(dp),
        .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]),
        .i_idx(i_o[0]), .j_idx(j_o[0]), .k_idx(k_o[0]),
        .rd_en(rd_o[0]), .addr_a(aa_o[0]), .addr_b(ab_o[0]),
        .wr_en(wr_o[0]), .addr_c(ac_o[0]),
        .mac_clr(clr_o[0]), .mac_en(mac_o[0])
`ifdef MATMUL_CTRL_ABORT_EN
        , .abort(abort_i[0]), .aborted(aborted_o[0])
`endif
    );

    matmul_loop_ctrl #(.DATA_WIDTH(W), .MEM_LAT(1)) dut_lat1 (
        .clk(clk), .rst_n(rst_n), .start(start_i[1]),
        .dim_m(dm), .dim_n(dn), .dim_p(dp),
        .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]),
        .i_idx(i_o[1]), .j_idx(j_o[1]), .k_idx(k_o[1]),
        .rd_en(rd_o[1]), .addr_a(aa_o[1]), .addr_b(ab_o[1]),
        .wr_en(wr_o[1]), .addr_c(ac_o[1]),
        .mac_clr(clr_o[1]), .mac_en(mac_o[1])
`ifdef MATMUL_CTRL_ABORT_EN
        , .abort(abort_i[1]), .aborted(aborted_o[1])
`endif
    );

    function automatic exp_t mk(input logic [3:0] strb, input logic d, input int i, input int j, input int k);
        exp_t e;
        e.strb = strb;
        e.dn   = d;
        e.i    = W'(i);
        e.j    = W'(j);
        e.k    = W'(k);
        return e;
    endfunction

    // One entry per cycle, starting with the cycle after the accepted start.
    function automatic void build(input int m, input int n, input int p, input int lat);
        exp_q.delete();
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < p; j++) begin
                exp_q.push_back(mk(4'b1000, 1'b0, i, j, 0));
                for (int k = 0; k < n; k++) begin
                    exp_q.push_back(mk(4'b0100, 1'b0, i, j, k));
                    for (int w = 0; w < lat - 1; w++) exp_q.push_back(mk(4'b0000, 1'b0, i, j, k));
                    exp_q.push_back(mk(4'b0010, 1'b0, i, j, k));
                end
                exp_q.push_back(mk(4'b0001, 1'b0, i, j, n - 1));
            end
        end
        exp_q.push_back(mk(4'b0000, 1'b1, m - 1, p - 1, 0));
    endfunction

    task automatic wait_idle(input int s);
        int n;
        n = 0;
        while (busy_o[s] === 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy_o[s] !== 1'b0) begin
            failures++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, expected 0", busy_o[s], n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_i = 2'b11;
        dm = 8'd3; dn = 8'd2; dp = 8'd1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({busy_o[s], done_o[s], err_o[s], i_o[s], j_o[s], k_o[s], rd_o[s], aa_o[s], ab_o[s],
                 wr_o[s], ac_o[s], clr_o[s], mac_o[s]} !== '0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d: busy=%b done=%b err=%b i=%0d addr_a=%0d expected all 0",
                         s, busy_o[s], done_o[s], err_o[s], i_o[s], aa_o[s]);
            end
        end
        start_i = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_runs();
        int cm[5] = '{1, 2, 1, 1, 2};
        int cn[5] = '{1, 2, 3, 255, 1};
        int cp[5] = '{1, 2, 1, 1, 255};
        int cs[5] = '{0, 0, 1, 1, 1};
        int m, n, p, s, lat, nmac, nclr, nwr, ea, eb, ec;
        bit noise;
        exp_t e;
        for (int r = 0; r < 13; r++) begin
            if (r < 5) begin
                m = cm[r]; n = cn[r]; p = cp[r]; s = cs[r]; noise = 1'b0;
            end else begin
                m = int'($urandom_range(1, 3)); n = int'($urandom_range(1, 3));
                p = int'($urandom_range(1, 3)); s = int'($urandom_range(0, 1)); noise = 1'b1;
            end
            lat = (s == 1) ? 1 : 2;
            build(m, n, p, lat);
            nmac = 0; nclr = 0; nwr = 0;
            @(negedge clk);
            dm = W'(m); dn = W'(n); dp = W'(p);
            start_i[s] = 1'b1;
            for (int c = 0; c < exp_q.size(); c++) begin
                @(negedge clk);
                if (noise && c != exp_q.size() - 1) begin
                    start_i[s] = 1'($urandom_range(0, 1));
                    dm = W'($urandom); dn = W'($urandom); dp = W'($urandom);
                end else begin
                    start_i[s] = 1'b0;
                end
                e = exp_q[c];
                ea = int'(e.i) * n + int'(e.k);
                eb = int'(e.k) * p + int'(e.j);
                ec = int'(e.i) * p + int'(e.j);
                nmac += int'(mac_o[s]); nclr += int'(clr_o[s]); nwr += int'(wr_o[s]);
                checks++;
                if ({clr_o[s], rd_o[s], mac_o[s], wr_o[s], done_o[s], busy_o[s], err_o[s]} !== {e.strb, e.dn, 1'b1, 1'b0}) begin
                    failures++;
                    $display("FAIL run%0d_ctrl cyc %0d: clr/rd/mac/wr/done/busy/err=%b%b%b%b%b%b%b expected %b%b11",
                             r, c + 1, clr_o[s], rd_o[s], mac_o[s], wr_o[s], done_o[s], busy_o[s], err_o[s], e.strb, e.dn);
                end
                checks++;
                if ({i_o[s], j_o[s], k_o[s]} !== {e.i, e.j, e.k}) begin
                    failures++;
                    $display("FAIL run%0d_idx cyc %0d: i/j/k=%0d/%0d/%0d expected %0d/%0d/%0d",
                             r, c + 1, i_o[s], j_o[s], k_o[s], e.i, e.j, e.k);
                end
                checks++;
                if ({aa_o[s], ab_o[s], ac_o[s]} !== {ea[AW-1:0], eb[AW-1:0], ec[AW-1:0]}) begin
                    failures++;
                    $display("FAIL run%0d_addr cyc %0d: a/b/c=%0d/%0d/%0d expected %0d/%0d/%0d",
                             r, c + 1, aa_o[s], ab_o[s], ac_o[s], ea, eb, ec);
                end
            end
            @(negedge clk);
            checks++;
            if ({busy_o[s], done_o[s], clr_o[s], rd_o[s], mac_o[s], wr_o[s]} !== 6'b0) begin
                failures++;
                $display("FAIL run%0d_idle: busy/done/strobes=%b%b%b%b%b%b expected 000000",
                         r, busy_o[s], done_o[s], clr_o[s], rd_o[s], mac_o[s], wr_o[s]);
            end
            checks++;
            if (nmac != m * n * p || nclr != m * p || nwr != m * p) begin
                failures++;
                $display("FAIL run%0d_counts: mac=%0d clr=%0d wr=%0d expected %0d %0d %0d",
                         r, nmac, nclr, nwr, m * n * p, m * p, m * p);
            end
        end
    endtask

    task automatic test_zero_dim();
        @(negedge clk);
        dm = 8'd2; dn = 8'd0; dp = 8'd2;
        start_i[0] = 1'b1;
        @(negedge clk);
        start_i[0] = 1'b0;
        checks++;
        if ({done_o[0], busy_o[0], err_o[0], clr_o[0], rd_o[0], mac_o[0], wr_o[0]} !== 7'b1110000) begin
            failures++;
            $display("FAIL zero_dim_done: done/busy/err/strobes=%b%b%b%b%b%b%b expected 1110000",
                     done_o[0], busy_o[0], err_o[0], clr_o[0], rd_o[0], mac_o[0], wr_o[0]);
        end
        @(negedge clk);
        checks++;
        if ({done_o[0], busy_o[0], err_o[0]} !== 3'b001) begin
            failures++;
            $display("FAIL zero_dim_sticky: done/busy/err=%b%b%b expected 001", done_o[0], busy_o[0], err_o[0]);
        end
        dm = 8'd1; dn = 8'd1; dp = 8'd1;
        start_i[0] = 1'b1;
        @(negedge clk);
        start_i[0] = 1'b0;
        checks++;
        if ({err_o[0], clr_o[0], busy_o[0]} !== 3'b011) begin
            failures++;
            $display("FAIL zero_dim_clear: err/mac_clr/busy=%b%b%b expected 011", err_o[0], clr_o[0], busy_o[0]);
        end
        wait_idle(0);
    endtask

    task automatic test_start_held();
        @(negedge clk);
        dm = 8'd1; dn = 8'd1; dp = 8'd1;
        start_i[0] = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (done_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL held_done: done=%b at cycle 6 expected 1", done_o[0]);
        end
        @(negedge clk);
        checks++;
        if ({busy_o[0], done_o[0]} !== 2'b00) begin
            failures++;
            $display("FAIL held_idle: busy/done=%b%b expected 00", busy_o[0], done_o[0]);
        end
        @(negedge clk);
        start_i[0] = 1'b0;
        checks++;
        if ({busy_o[0], clr_o[0]} !== 2'b11) begin
            failures++;
            $display("FAIL held_restart: busy/mac_clr=%b%b expected 11", busy_o[0], clr_o[0]);
        end
        wait_idle(0);
    endtask

    task automatic test_reset_mid();
        int done_cyc, nwr;
        build(2, 2, 2, 2);
        @(negedge clk);
        dm = 8'd2; dn = 8'd2; dp = 8'd2;
        start_i[0] = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start_i[0] = c[0];
            dm = 8'd3; dn = 8'd1; dp = 8'd4;
            checks++;
            if ({clr_o[0], rd_o[0], mac_o[0], wr_o[0], i_o[0], j_o[0], k_o[0]} !==
                {exp_q[c - 1].strb, exp_q[c - 1].i, exp_q[c - 1].j, exp_q[c - 1].k}) begin
                failures++;
                $display("FAIL midstart cyc %0d: strobes=%b%b%b%b k=%0d expected %b k=%0d",
                         c, clr_o[0], rd_o[0], mac_o[0], wr_o[0], k_o[0], exp_q[c - 1].strb, exp_q[c - 1].k);
            end
        end
        @(negedge clk);
        start_i[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_o[0], done_o[0], err_o[0], i_o[0], j_o[0], k_o[0], rd_o[0], aa_o[0], ab_o[0],
             wr_o[0], ac_o[0], clr_o[0], mac_o[0]} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: busy=%b rd=%b mac=%b k=%0d addr_a=%0d expected all 0",
                     busy_o[0], rd_o[0], mac_o[0], k_o[0], aa_o[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({busy_o[0], done_o[0]} !== 2'b00) begin
                failures++;
                $display("FAIL midreset_quiet: busy/done=%b%b expected 00", busy_o[0], done_o[0]);
            end
        end
        dm = 8'd2; dn = 8'd2; dp = 8'd2;
        start_i[0] = 1'b1;
        done_cyc = 0; nwr = 0;
        for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
            @(negedge clk);
            start_i[0] = 1'b0;
            nwr += int'(wr_o[0]);
            if (done_o[0] === 1'b1) done_cyc = c;
        end
        checks++;
        if (done_cyc != 33 || nwr != 4) begin
            failures++;
            $display("FAIL fresh_run: done at %0d with %0d writes, expected 33 with 4", done_cyc, nwr);
        end
        wait_idle(0);
    endtask

`ifdef MATMUL_CTRL_ABORT_EN
    task automatic test_abort();
        int bad;
        @(negedge clk);
        abort_i[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (aborted_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: aborted=%b expected 0", aborted_o[0]);
        end
        abort_i[0] = 1'b0;
        dm = 8'd2; dn = 8'd2; dp = 8'd2;
        start_i[0] = 1'b1;
        repeat (7) @(negedge clk);
        start_i[0] = 1'b0;
        abort_i[0] = 1'b1;
        @(negedge clk);
        abort_i[0] = 1'b0;
        checks++;
        if ({aborted_o[0], busy_o[0], done_o[0], clr_o[0], rd_o[0], mac_o[0], wr_o[0], i_o[0], j_o[0], k_o[0]} !==
            {1'b1, 6'b0, 24'b0}) begin
            failures++;
            $display("FAIL abort_cycle8: aborted=%b busy=%b done=%b wr=%b k=%0d expected 1 0 0 0 0",
                     aborted_o[0], busy_o[0], done_o[0], wr_o[0], k_o[0]);
        end
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (wr_o[0] !== 1'b0 || done_o[0] !== 1'b0 || aborted_o[0] !== 1'b0 || busy_o[0] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL abort_after: %0d cycles with activity, expected 0", bad);
        end
    endtask
`endif

    initial begin
        start_i = 2'b00;
        dm = '0; dn = '0; dp = '0;
`ifdef MATMUL_CTRL_ABORT_EN
        abort_i = 2'b00;
`endif
        test_reset();
        test_runs();
        test_zero_dim();
        test_start_held();
        test_reset_mid();
`ifdef MATMUL_CTRL_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
